riscv_retire_trace: RTL and testbench
=====================================

// Module: riscv_retire_trace
// PURPOSE
//  Synthesisable retire-trace capture for the RISC-V core; replaces ad-hoc hierarchical peeks at PC/instr/writeback.
//  Records one entry per retired instruction (PC, instr, rd write, cycle stamp) in a circular buffer.
//  Supports PC breakpoints with post-trigger capture and freeze, and drains entries over a valid/ready port.
//  Sits beside the core; taps the retire/writeback signals, and its halt_req feeds the PC-enable path.
// PARAMETERS
//  XLEN       32  data/PC width
//  DEPTH      16  trace entries (power of 2, >=4)
//  NUM_BP     2   PC breakpoint comparators
//  POST_TRIG  4   entries captured after a trigger before freezing (0..DEPTH-1)
//  TS_W       16  cycle-stamp width
// PORTS
//  clk            in   1                  clock, rising edge
//  reset          in   1                  synchronous, active-high
//  ret_valid      in   1                  instruction retired this cycle
//  ret_pc         in   XLEN               PC of retired instruction
//  ret_instr      in   32                 instruction word
//  ret_we         in   1                  register-file write enable
//  ret_rd         in   5                  write index
//  ret_wdata      in   XLEN               write data
//  arm            in   1                  pulse: clear buffer, enter RUN
//  wrap_mode      in   1                  1=overwrite oldest when full; 0=stop when full
//  bp_en          in   NUM_BP             per-breakpoint enable
//  bp_pc          in   NUM_BP*XLEN        breakpoint PCs, packed, bp0 in LSBs
//  halt_req       out  1                  core stall request (asserted in FROZEN)
//  out_valid      out  1                  drain entry available
//  out_ready      in   1                  drain accept
//  out_pc/out_instr/out_rd/out_wdata/out_we/out_ts  out  entry fields (out_ts is TS_W)
//  count          out  $clog2(DEPTH)+1    entries held
//  overflow       out  1                  sticky: entry overwritten (wrap) or dropped (no wrap)
//  state          out  2                  current FSM state, for debug
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr, rd_ptr, count, ts, post-trigger counter = 0; halt_req=0, out_valid=0, overflow=0.
//  FSM: IDLE -arm-> RUN; RUN -bp hit-> POST; POST -counter==POST_TRIG-> FROZEN; FROZEN -arm-> RUN.
//   arm in any state: flush the buffer, clear overflow/ts, go to RUN. arm beats a same-cycle bp hit.
//  ts free-runs in RUN and POST (+1 per clk, wraps modulo 2^TS_W); held in IDLE and FROZEN.
//  Capture: in RUN/POST, a ret_valid entry is written at wr_ptr on the same edge; 1-cycle latency to count/out_valid.
//  bp hit = ret_valid & OR_i(bp_en[i] & ret_pc==bp_pc[i]). The hitting instruction is itself captured.
//   POST counts further captured entries; POST_TRIG=0 -> RUN goes straight to FROZEN on the hit.
//  Full (count==DEPTH) plus capture: wrap_mode=1 -> overwrite the oldest entry, rd_ptr+1, count unchanged, overflow=1.
//   wrap_mode=0 -> drop the entry, overflow=1; the bp check still applies.
//  Drain: out_valid = (count!=0); the fields show the entry at rd_ptr, driven combinationally from storage.
//   out_valid & out_ready pops the entry. Draining is allowed in every state, including FROZEN.
//   Pop and capture on the same cycle leave count unchanged.
//   Pop plus a wrap-overwrite on a full buffer: rd_ptr advances once only.
//  Pointers are $clog2(DEPTH) bits and wrap naturally; count saturates at DEPTH.
//  halt_req = (state==FROZEN), registered. In FROZEN, ret_valid is ignored.
//  Reset mid-capture: everything returns to reset values; the storage contents are don't-care.
// STRUCTURE
//  Package riscv_trace_pkg: typedef enum {IDLE,RUN,POST,FROZEN} trace_state_e; typedef struct trace_entry_t.
//  One sub-module, trace_fifo_mem: DEPTH x entry register array, 1 write port, async read port.
//  The FSM, pointers, counter and breakpoint compare stay in this top level.
// TESTING
//  1. Reset, arm, 5 retires pc=0x0,0x4..0x10 -> count=5; drain yields pcs 0x0..0x10 in order, ts 0..4 ascending.
//  2. DEPTH=16, wrap_mode=1, 20 retires pc=4*i -> count=16, overflow=1, first drained pc=0x10, last=0x4C.
//  3. wrap_mode=0, same stimulus -> count=16, overflow=1, drained pcs 0x0..0x3C.
//  4. bp0=0x20 enabled, POST_TRIG=4, retire pc 0x0.. -> FROZEN after pc=0x30; halt_req=1; last entry pc=0x30.
//  5. Full buffer with a capture and pop on the same cycle (wrap) -> count stays 16, rd_ptr advances once.
//  6. Assert reset while in POST -> next cycle state=IDLE, count=0, halt_req=0, overflow=0; arm restarts ts at 0.

Source files
------------

// File: rtl/riscv_retire_trace_pkg.sv
// Shared types for the retire-trace capture block: FSM states and the stored entry layout.
package riscv_trace_pkg;
  localparam int XLEN = 32;
  localparam int TS_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, POST, FROZEN} trace_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [TS_W-1:0] ts;
  } trace_entry_t;
endpackage

// File: rtl/riscv_retire_trace_if.sv
// Retire tap from the core plus the valid/ready drain port of the trace buffer.
interface riscv_retire_trace_if import riscv_trace_pkg::*; ();
  logic            ret_valid;
  logic [XLEN-1:0] ret_pc;
  logic [31:0]     ret_instr;
  logic            ret_we;
  logic [4:0]      ret_rd;
  logic [XLEN-1:0] ret_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_wdata;
  logic            out_we;
  logic [TS_W-1:0] out_ts;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata, out_ready,
    input  out_valid, out_pc, out_instr, out_rd, out_wdata, out_we, out_ts
  );
  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata, out_ready,
    output out_valid, out_pc, out_instr, out_rd, out_wdata, out_we, out_ts
  );
endinterface

// File: rtl/riscv_retire_trace_mem.sv
// Trace entry storage: one synchronous write port, one asynchronous read port, no reset.
module trace_fifo_mem import riscv_trace_pkg::*; #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdata
);
  trace_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/riscv_retire_trace.sv
// Retire-trace capture: circular buffer of retired instructions with PC breakpoints,
// post-trigger capture, freeze/halt and a valid/ready drain port.
module riscv_retire_trace import riscv_trace_pkg::*; #(
  parameter  int DEPTH     = 16,
  parameter  int NUM_BP    = 2,
  parameter  int POST_TRIG = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_retire_trace_if.slave           tr,
  input  logic                          arm,
  input  logic                          wrap_mode,
  input  logic [NUM_BP-1:0]             bp_en,
  input  logic [NUM_BP-1:0][XLEN-1:0]   bp_pc,
  output logic                          halt_req,
  output logic [CW-1:0]                 count,
  output logic                          overflow,
  output logic [1:0]                    state
);
  trace_state_e    state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            overflow_q, overflow_d, halt_q, halt_d;
  logic            mem_we, active, capture, pop, full, bp_hit;
  logic [NUM_BP-1:0] bp_match;
  trace_entry_t    wr_entry, rd_entry;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (tr.ret_pc == bp_pc[i]);
  end

  assign active  = (state_q == RUN) || (state_q == POST);
  assign capture = active && tr.ret_valid;
  assign pop     = (count_q != '0) && tr.out_ready;
  assign full    = (count_q == CW'(DEPTH));
  assign bp_hit  = tr.ret_valid && (|bp_match);

  assign wr_entry = '{pc: tr.ret_pc, instr: tr.ret_instr, rd: tr.ret_rd,
                      wdata: tr.ret_wdata, we: tr.ret_we, ts: ts_q};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ts_d       = ts_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (arm) begin
      state_d    = RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ts_d       = '0;
      post_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (active) ts_d = ts_q + 1'b1;
      if (capture && full) begin
        overflow_d = 1'b1;
        // The oldest entry leaves once, whether by overwrite or by a same-cycle pop.
        if (wrap_mode) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
      end else begin
        if (capture) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (capture && !pop) count_d = count_q + 1'b1;
        else if (pop && !capture) count_d = count_q - 1'b1;
      end
      case (state_q)
        RUN: if (bp_hit) begin
          state_d    = (POST_TRIG == 0) ? FROZEN : POST;
          post_cnt_d = '0;
        end
        POST: if (capture) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (CW'(post_cnt_q) + CW'(1) == CW'(POST_TRIG)) state_d = FROZEN;
        end
        default: ;
      endcase
    end
    halt_d = (state_d == FROZEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
    end
  end

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign tr.out_valid = (count_q != '0);
  assign tr.out_pc    = rd_entry.pc;
  assign tr.out_instr = rd_entry.instr;
  assign tr.out_rd    = rd_entry.rd;
  assign tr.out_wdata = rd_entry.wdata;
  assign tr.out_we    = rd_entry.we;
  assign tr.out_ts    = rd_entry.ts;
  assign halt_req     = halt_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign state        = state_q;
endmodule

// File: tb/tb_riscv_retire_trace.sv
// Bench for riscv_retire_trace: directed scenarios then random traffic, all checked
// against a queue-based reference model of the trace buffer.
module tb_riscv_retire_trace;
  import riscv_trace_pkg::*;
  localparam int DEPTH = 16, NUM_BP = 2, POST_TRIG = 4;

  typedef struct {
    logic [31:0] pc, instr, wdata;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ts;
  } ent_t;

  logic clk = 1'b0, reset = 1'b1, arm = 1'b0, wrap_mode = 1'b0;
  logic [NUM_BP-1:0]            bp_en = '0;
  logic [NUM_BP-1:0][31:0]      bp_pc = '0;
  logic                         halt_req, overflow;
  logic [4:0]                   count;
  logic [1:0]                   dut_state;
  riscv_retire_trace_if tif ();

  riscv_retire_trace #(.DEPTH(DEPTH), .NUM_BP(NUM_BP), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .reset(reset), .tr(tif), .arm(arm), .wrap_mode(wrap_mode),
    .bp_en(bp_en), .bp_pc(bp_pc), .halt_req(halt_req), .count(count),
    .overflow(overflow), .state(dut_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  ent_t mq[$];
  trace_state_e mst = IDLE;
  int mts = 0, mpost = 0;
  bit movf = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT, compare.
  task automatic step();
    bit pop, cap, full, hit, was_active;
    ent_t e;
    pop = (mq.size() != 0) && tif.out_ready;
    if (reset || arm) begin
      mq.delete(); mts = 0; movf = 0; mpost = 0;
      mst = reset ? IDLE : RUN;
    end else begin
      was_active = (mst == RUN) || (mst == POST);
      cap  = tif.ret_valid && was_active;
      full = (mq.size() == DEPTH);
      hit  = 1'b0;
      for (int b = 0; b < NUM_BP; b++)
        if (tif.ret_valid && bp_en[b] && tif.ret_pc == bp_pc[b]) hit = 1'b1;
      e = '{pc: tif.ret_pc, instr: tif.ret_instr, wdata: tif.ret_wdata,
            rd: tif.ret_rd, we: tif.ret_we, ts: 16'(mts)};
      if (cap && full) begin
        movf = 1;
        if (wrap_mode) begin void'(mq.pop_front()); mq.push_back(e); end
        else if (pop) void'(mq.pop_front());
      end else begin
        if (pop) void'(mq.pop_front());
        if (cap) mq.push_back(e);
      end
      if (mst == RUN && hit) begin
        mst = (POST_TRIG == 0) ? FROZEN : POST; mpost = 0;
      end else if (mst == POST && cap) begin
        mpost++;
        if (mpost == POST_TRIG) mst = FROZEN;
      end
      if (was_active) mts = (mts + 1) & 16'hFFFF;
    end
    @(posedge clk); #1;
    chk("state", dut_state, mst);
    chk("count", count, mq.size());
    chk("out_valid", tif.out_valid, mq.size() != 0);
    chk("overflow", overflow, movf);
    chk("halt_req", halt_req, mst == FROZEN);
    if (mq.size() != 0) begin
      chk("out_pc", tif.out_pc, mq[0].pc);
      chk("out_instr", tif.out_instr, mq[0].instr);
      chk("out_rd", tif.out_rd, mq[0].rd);
      chk("out_wdata", tif.out_wdata, mq[0].wdata);
      chk("out_we", tif.out_we, mq[0].we);
      chk("out_ts", tif.out_ts, mq[0].ts);
    end
  endtask

  task automatic ret(input logic [31:0] pc);
    tif.ret_valid = 1'b1; tif.ret_pc = pc; tif.ret_instr = $urandom;
    tif.ret_we = 1'($urandom); tif.ret_rd = 5'($urandom); tif.ret_wdata = $urandom;
    step();
    tif.ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  logic [31:0] last_pc;

  initial begin
    tif.ret_valid = 1'b0; tif.ret_pc = '0; tif.ret_instr = '0; tif.ret_we = 1'b0;
    tif.ret_rd = '0; tif.ret_wdata = '0; tif.out_ready = 1'b0;
    step(); reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_state", dut_state, 0);

    // 1: five retires, in-order drain with ascending stamps
    do_arm();
    for (int i = 0; i < 5; i++) ret(32'(4 * i));
    chk("t1_count", count, 5);
    tif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t1_pc", tif.out_pc, 4 * i);
      chk("t1_ts", tif.out_ts, i);
      step();
    end
    tif.out_ready = 1'b0;

    // 2: wrap mode, 20 retires into 16 entries
    wrap_mode = 1'b1; do_arm();
    for (int i = 0; i < 20; i++) ret(32'(4 * i));
    chk("t2_count", count, 16);
    chk("t2_ovf", overflow, 1);
    chk("t2_first", tif.out_pc, 32'h10);
    tif.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin last_pc = tif.out_pc; step(); end
    tif.out_ready = 1'b0;
    chk("t2_last", last_pc, 32'h4C);

    // 3: stop-when-full keeps the oldest 16
    wrap_mode = 1'b0; do_arm();
    for (int i = 0; i < 20; i++) ret(32'(4 * i));
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_first", tif.out_pc, 32'h0);
    tif.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin last_pc = tif.out_pc; step(); end
    tif.out_ready = 1'b0;
    chk("t3_last", last_pc, 32'h3C);

    // 4: breakpoint at 0x20 (bp1 disabled at 0x8), freeze after four more
    bp_pc[0] = 32'h20; bp_pc[1] = 32'h8; bp_en = 2'b01; do_arm();
    for (int i = 0; i < 13; i++) ret(32'(4 * i));
    chk("t4_state", dut_state, 3);
    chk("t4_halt", halt_req, 1);
    ret(32'h34);
    chk("t4_count", count, 13);
    tif.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin last_pc = tif.out_pc; step(); end
    tif.out_ready = 1'b0;
    chk("t4_last", last_pc, 32'h30);
    bp_en = '0;

    // 5: full wrapped buffer, capture and pop together
    wrap_mode = 1'b1; do_arm();
    for (int i = 0; i < 17; i++) ret(32'(4 * i));
    chk("t5_front", tif.out_pc, 32'h4);
    tif.out_ready = 1'b1; ret(32'h100); tif.out_ready = 1'b0;
    chk("t5_count", count, 16);
    chk("t5_pc", tif.out_pc, 32'h8);

    // 6: reset while in POST, then re-arm restarts the stamp
    bp_pc[0] = 32'h8; bp_en = 2'b01; do_arm();
    for (int i = 0; i < 4; i++) ret(32'(4 * i));
    chk("t6_post", dut_state, 2);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_state", dut_state, 0);
    chk("t6_count", count, 0);
    chk("t6_halt", halt_req, 0);
    chk("t6_ovf", overflow, 0);
    bp_en = '0; do_arm(); ret(32'h40);
    chk("t6_ts", tif.out_ts, 0);

    // random traffic
    bp_pc[0] = 32'h28; bp_pc[1] = 32'h3C;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      arm   = !reset && ($urandom_range(0, 59) == 0);
      if (arm) wrap_mode = 1'($urandom);
      if ($urandom_range(0, 49) == 0) bp_en = 2'($urandom);
      tif.ret_valid = ($urandom_range(0, 9) < 6);
      tif.ret_pc    = 32'(4 * $urandom_range(0, 15));
      tif.ret_instr = $urandom; tif.ret_we = 1'($urandom);
      tif.ret_rd    = 5'($urandom); tif.ret_wdata = $urandom;
      tif.out_ready = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
